// File: rtl/instr_encoder_b.sv
// -----------------------------------------------------------------------------
// instr_encoder_b
//
// Packs RISC-V conditional-branch fields into a 32-bit B-type instruction and
// queues the result for a downstream consumer. Each emitted instruction gets a
// byte address taken from a running counter. The counter starts at BASE_ADDR
// and advances by 4 on every output beat.
//
// A beat is rejected if it has an illegal branch condition (func3 010/011) or
// an odd byte offset. A rejected beat is consumed but never queued. Each
// rejection produces a one-cycle err pulse and bumps a saturating counter.
//
// Ports
//   clk        in   1   single clock, rising edge
//   rst_n      in   1   synchronous active-low reset
//   in_valid   in   1   branch fields valid
//   in_ready   out  1   queue has room (registered occupancy only)
//   cmp_op     in   3   branch condition / func3
//   rs1, rs2   in   5   source register indices
//   immediate  in  13   signed byte offset
//   out_valid  out  1   out_instr / out_addr valid
//   out_ready  in   1   consumer takes the beat
//   out_instr  out 32   encoded B-type instruction
//   out_addr   out 32   byte address of out_instr
//   err        out  1   pulse: a rejected beat fired last cycle
//   err_cnt    out  8   saturating count of rejected beats
// -----------------------------------------------------------------------------
module instr_encoder_b #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  cmp_op,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] immediate,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err,
    output logic [7:0]  err_cnt
);

    localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [6:0]  OPC_BR   = 7'b1100011;

    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [31:0]   addr_q, addr_d;
    logic          err_q, err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic          in_fire;
    logic          reject;
    logic          push;
    logic          pop;
    logic [31:0]   instr_enc;

    // in_ready depends only on registered occupancy. This keeps out_ready
    // off any combinational path to in_ready: a full queue refuses a beat
    // even in a cycle where it is also popping.
    assign in_ready  = (count_q != FULL_CNT);
    assign out_valid = (count_q != '0);
    assign out_instr = mem_q[rd_ptr_q];
    assign out_addr  = addr_q;
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

    assign in_fire = in_valid && in_ready;
    assign reject  = (cmp_op == 3'b010) || (cmp_op == 3'b011) || immediate[0];
    assign push    = in_fire && !reject;
    assign pop     = out_valid && out_ready;

    assign instr_enc = {immediate[12], immediate[10:5], rs2, rs1, cmp_op,
                        immediate[4:1], immediate[11], OPC_BR};

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        addr_d    = addr_q;
        err_d     = in_fire && reject;
        err_cnt_d = err_cnt_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            addr_d   = addr_q + 32'd4;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (in_fire && reject && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            addr_q    <= BASE_ADDR;
            err_q     <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Storage needs no reset. Only slots between rd_ptr and wr_ptr are ever
    // observed, and reset collapses that window to empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= instr_enc;
        end
    end

endmodule

// File: doc/instr_encoder_b.md
INSTR_ENCODER_B -- requirements
Module: instr_encoder_B

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the first instruction byte address emitted after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the output queue entries (power of two, 2..8).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, a synchronous active-low reset sampled on the rising edge of clk.
REQ-005 SHALL have port in_valid, input, 1, meaning the branch fields are valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts a beat this cycle.
REQ-007 SHALL have port cmp_op, input, 3, the branch condition, equal to func3 (000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU).
REQ-008 SHALL have ports rs1 and rs2, input, 5 each, the source register indices.
REQ-009 SHALL have port immediate, input, 13, the signed byte offset.
REQ-010 SHALL have port out_valid, output, 1, meaning out_instr and out_addr are valid.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer takes the beat.
REQ-012 SHALL have port out_instr, output, 32, the encoded B-type instruction.
REQ-013 SHALL have port out_addr, output, 32, the byte address assigned to out_instr.
REQ-014 SHALL have port err, output, 1, a one-cycle pulse when a rejected beat was accepted.
REQ-015 SHALL have port err_cnt, output, 8, a saturating count of rejected beats.

Function
REQ-016 SHALL fire an input beat when in_valid && in_ready, and an output beat when out_valid && out_ready.
REQ-017 SHALL drive in_ready = (queue not full); there is no combinational path from out_ready to in_ready.
REQ-018 SHALL encode: [31]=imm[12], [30:25]=imm[10:5], [24:20]=rs2, [19:15]=rs1, [14:12]=cmp_op, [11:8]=imm[4:1], [7]=imm[11], [6:0]=7'b1100011.
REQ-019 SHALL reject a fired beat if cmp_op is 010 or 011, or if immediate[0]=1; a rejected beat is consumed, not queued.
REQ-020 SHALL assert err for exactly the one cycle after a rejected beat fires, and increment err_cnt in that same cycle, saturating at 8'hFF.
REQ-021 SHALL make a valid fired beat visible at the queue head no earlier than the next cycle, giving a minimum latency of 1 cycle from in fire to out_valid.
REQ-022 SHALL preserve FIFO order; out_instr is held stable while out_valid && !out_ready.
REQ-023 SHALL hold an address counter that is out_addr while out_valid, and add 4 on each output fire, wrapping modulo 2^32.
REQ-024 SHALL, on a simultaneous push and pop with the queue non-empty and not full, keep occupancy unchanged and keep both beats correct.
REQ-025 SHALL not change the queue on a push into a full queue, because in_ready=0 and the beat does not fire.
REQ-026 SHALL drive out_valid=0 when empty and leave out_instr don't-care; the bench checks out_instr only when out_valid=1.

Reset
REQ-027 SHALL, while rst_n=0 at a clk edge, empty the queue, set out_valid=0, err=0, err_cnt=0, and the address counter to BASE_ADDR.
REQ-028 SHALL drive in_ready=1 in the first cycle after reset deasserts.
REQ-029 SHALL discard a beat presented in the same cycle as reset, and drop queued beats without emitting them.

Verification
REQ-030 SHALL pass the BNE encode case: cmp_op=001, rs1=1, rs2=2, immediate=13'h1FFC, out_ready=1 -> next cycle out_valid=1, out_instr=32'hFE209EE3, out_addr=BASE_ADDR.
REQ-031 SHALL pass the BEQ encode case: cmp_op=000, rs1=0, rs2=1, immediate=32 -> out_instr=32'h02100063; a following beat is emitted with out_addr=BASE_ADDR+4.
REQ-032 SHALL pass the reject case: cmp_op=010 (and separately immediate=13'h0003) -> no out_valid, err pulses 1 cycle, err_cnt increments 0->1->2.
REQ-033 SHALL pass the backpressure case: out_ready=0, push 3 valid beats -> in_ready=0 after 2 accepted; release out_ready -> beats emerge in order at consecutive addresses.
REQ-034 SHALL pass the wrap and saturation cases: BASE_ADDR=32'hFFFF_FFFC, emit 2 beats -> out_addr FFFF_FFFC then 0000_0000; 300 rejects -> err_cnt=8'hFF.
REQ-035 SHALL pass the mid-operation reset case: queue full, rst_n=0 for one edge -> out_valid=0, err_cnt=0, then the next beat is at BASE_ADDR.
